// File: rtl/llmint8_absmax_quantizer.sv
// Absmax INT8 quantiser with outlier split.
// Buffers NUM_BEATS input beats, tracks the absmax of non-outlier elements,
// derives a power-of-two right shift, then replays the buffered beats as
// rounded, saturated signed integers plus a per-element outlier mask.
module llmint8_absmax_quantizer #(
    parameter int IN_WIDTH       = 16,
    parameter int IN_SIZE        = 4,
    parameter int IN_PARALLELISM = 1,
    parameter int OUT_WIDTH      = 8,
    parameter int NUM_BEATS      = 2,
    parameter int SCALE_MODE     = 0,
    parameter int THRESHOLD      = 2 ** (IN_WIDTH - 1)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [IN_PARALLELISM*IN_SIZE*IN_WIDTH-1:0]       data_in,
    input  logic                                             data_in_valid,
    output logic                                             data_in_ready,
    output logic [IN_PARALLELISM*IN_SIZE*OUT_WIDTH-1:0]      data_out,
    output logic [IN_PARALLELISM*IN_SIZE-1:0]                outlier_mask,
    output logic [$clog2(IN_WIDTH):0]                        scale_shift,
    output logic                                             data_out_valid,
    input  logic                                             data_out_ready,
    output logic                                             data_out_last
);

    localparam int N     = IN_PARALLELISM * IN_SIZE;
    localparam int SHW   = $clog2(IN_WIDTH) + 1;
    localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic [IN_WIDTH:0]   THR_W     = (IN_WIDTH + 1)'(THRESHOLD);
    localparam logic [IN_WIDTH:0]   QMAX      = (IN_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_CALC,
        S_EMIT
    } state_e;

    // |x| as an unsigned IN_WIDTH value; the most negative input maps to 2^(IN_WIDTH-1).
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? ((~x) + IN_WIDTH'(1)) : x;
    endfunction

    function automatic logic is_outlier(input logic [IN_WIDTH-1:0] a);
        return ({1'b0, a} > THR_W);
    endfunction

    // Right shift that brings the absmax into OUT_WIDTH-1 magnitude bits.
    function automatic logic [SHW-1:0] shift_of(input logic [IN_WIDTH-1:0] m);
        int msb;
        msb = 0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (m[i]) msb = i;
        end
        if (msb > OUT_WIDTH - 2) return SHW'(msb - (OUT_WIDTH - 2));
        return '0;
    endfunction

    // Round half away from zero, then saturate symmetrically.
    function automatic logic [OUT_WIDTH-1:0] quant_elem(input logic [IN_WIDTH-1:0] x,
                                                        input logic [SHW-1:0]      sh);
        logic [IN_WIDTH:0] mag;
        mag = {1'b0, abs_val(x)};
        if (sh != '0) mag = mag + ((IN_WIDTH + 1)'(1) << (sh - SHW'(1)));
        mag = mag >> sh;
        if (mag > QMAX) mag = QMAX;
        if (x[IN_WIDTH-1]) mag = -mag;
        return mag[OUT_WIDTH-1:0];
    endfunction

    function automatic logic [IN_WIDTH-1:0] beat_absmax(input logic [N*IN_WIDTH-1:0] beat);
        logic [IN_WIDTH-1:0] best;
        logic [IN_WIDTH-1:0] a;
        best = '0;
        for (int e = 0; e < N; e++) begin
            a = abs_val(beat[e*IN_WIDTH +: IN_WIDTH]);
            if (!is_outlier(a) && (a > best)) best = a;
        end
        return best;
    endfunction

    function automatic logic [N-1:0] beat_outliers(input logic [N*IN_WIDTH-1:0] beat);
        logic [N-1:0] mask;
        mask = '0;
        for (int e = 0; e < N; e++) begin
            mask[e] = is_outlier(abs_val(beat[e*IN_WIDTH +: IN_WIDTH]));
        end
        return mask;
    endfunction

    function automatic logic [N*OUT_WIDTH-1:0] beat_quant(input logic [N*IN_WIDTH-1:0] beat,
                                                          input logic [SHW-1:0]        sh);
        logic [N*OUT_WIDTH-1:0] q;
        logic [IN_WIDTH-1:0]    x;
        q = '0;
        for (int e = 0; e < N; e++) begin
            x = beat[e*IN_WIDTH +: IN_WIDTH];
            if (!is_outlier(abs_val(x))) q[e*OUT_WIDTH +: OUT_WIDTH] = quant_elem(x, sh);
        end
        return q;
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]        emit_cnt_q, emit_cnt_d;
    logic [IN_WIDTH-1:0]     m_q [NUM_BEATS];
    logic [IN_WIDTH-1:0]     m_d [NUM_BEATS];
    logic [SHW-1:0]          shift_q [NUM_BEATS];
    logic [SHW-1:0]          shift_d [NUM_BEATS];
    logic [N*OUT_WIDTH-1:0]  data_out_q, data_out_d;
    logic [N-1:0]            mask_q, mask_d;
    logic [SHW-1:0]          scale_shift_q, scale_shift_d;
    logic [N*IN_WIDTH-1:0]   buf_q [NUM_BEATS];

    logic                    load_en;
    logic [CNT_W-1:0]        load_idx;
    logic [SHW-1:0]          load_shift;
    logic [IN_WIDTH-1:0]     in_max;

    assign data_in_ready  = (state_q == S_COLLECT);
    assign data_out_valid = (state_q == S_EMIT);
    assign data_out_last  = (state_q == S_EMIT) && (emit_cnt_q == LAST_BEAT);
    assign data_out       = data_out_q;
    assign outlier_mask   = mask_q;
    assign scale_shift    = scale_shift_q;

    // Next-state, absmax tracking and output-beat preparation.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        emit_cnt_d    = emit_cnt_q;
        m_d           = m_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        mask_d        = mask_q;
        scale_shift_d = scale_shift_q;
        load_en       = 1'b0;
        load_idx      = '0;
        load_shift    = '0;
        in_max        = beat_absmax(data_in);

        case (state_q)
            S_COLLECT: begin
                if (data_in_valid) begin
                    if (SCALE_MODE != 0) begin
                        m_d[beat_cnt_q] = in_max;
                    end else if (in_max > m_q[0]) begin
                        m_d[0] = in_max;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = S_CALC;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CALC: begin
                for (int i = 0; i < NUM_BEATS; i++) shift_d[i] = shift_of(m_q[i]);
                load_en    = 1'b1;
                load_idx   = '0;
                load_shift = shift_of(m_q[0]);
                emit_cnt_d = '0;
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                if (data_out_ready) begin
                    if (emit_cnt_q == LAST_BEAT) begin
                        state_d       = S_COLLECT;
                        emit_cnt_d    = '0;
                        for (int i = 0; i < NUM_BEATS; i++) m_d[i] = '0;
                        data_out_d    = '0;
                        mask_d        = '0;
                        scale_shift_d = '0;
                    end else begin
                        emit_cnt_d = emit_cnt_q + CNT_W'(1);
                        load_en    = 1'b1;
                        load_idx   = emit_cnt_q + CNT_W'(1);
                        load_shift = (SCALE_MODE != 0) ? shift_q[load_idx] : shift_q[0];
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase

        if (load_en) begin
            data_out_d    = beat_quant(buf_q[load_idx], load_shift);
            mask_d        = beat_outliers(buf_q[load_idx]);
            scale_shift_d = load_shift;
        end
    end

    // Control state, statistics and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_COLLECT;
            beat_cnt_q    <= '0;
            emit_cnt_q    <= '0;
            for (int i = 0; i < NUM_BEATS; i++) begin
                m_q[i]     <= '0;
                shift_q[i] <= '0;
            end
            data_out_q    <= '0;
            mask_q        <= '0;
            scale_shift_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            emit_cnt_q    <= emit_cnt_d;
            m_q           <= m_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            mask_q        <= mask_d;
            scale_shift_q <= scale_shift_d;
        end
    end

    // Beat buffer; a slot is always written before it is read back in EMIT.
    // NOTE: the buffer is a memory and deliberately has no reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_COLLECT) && data_in_valid) begin
            buf_q[beat_cnt_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_llmint8_absmax_quantizer.sv
// Self-checking bench: three quantiser instances (per-block scale, per-beat
// scale, per-block scale with THRESHOLD=500) share one stimulus stream and are
// compared against a plain-arithmetic reference model.
module tb_llmint8_absmax_quantizer;

    localparam int IW   = 16;
    localparam int OW   = 8;
    localparam int IS   = 4;
    localparam int IP   = 1;
    localparam int NB   = 2;
    localparam int N    = IS * IP;
    localparam int SW   = $clog2(IW) + 1;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*IW-1:0] data_in;
    logic            data_in_valid;
    logic            data_out_ready;

    logic [N*OW-1:0] dout [NCFG];
    logic [N-1:0]    mask [NCFG];
    logic [SW-1:0]   shft [NCFG];
    logic            vld  [NCFG];
    logic            lst  [NCFG];
    logic            rdy  [NCFG];

    llmint8_absmax_quantizer #(.IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(IP), .OUT_WIDTH(OW),
                               .NUM_BEATS(NB), .SCALE_MODE(0)) u_blk (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy[0]), .data_out(dout[0]), .outlier_mask(mask[0]),
        .scale_shift(shft[0]), .data_out_valid(vld[0]), .data_out_ready(data_out_ready),
        .data_out_last(lst[0]));

    llmint8_absmax_quantizer #(.IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(IP), .OUT_WIDTH(OW),
                               .NUM_BEATS(NB), .SCALE_MODE(1)) u_beat (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy[1]), .data_out(dout[1]), .outlier_mask(mask[1]),
        .scale_shift(shft[1]), .data_out_valid(vld[1]), .data_out_ready(data_out_ready),
        .data_out_last(lst[1]));

    llmint8_absmax_quantizer #(.IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(IP), .OUT_WIDTH(OW),
                               .NUM_BEATS(NB), .SCALE_MODE(0), .THRESHOLD(500)) u_thr (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy[2]), .data_out(dout[2]), .outlier_mask(mask[2]),
        .scale_shift(shft[2]), .data_out_valid(vld[2]), .data_out_ready(data_out_ready),
        .data_out_last(lst[2]));

    int              cur_blk   [NB][N];
    logic [N*OW-1:0] exp_data  [NCFG][NB];
    logic [N-1:0]    exp_mask  [NCFG][NB];
    int              exp_shift [NCFG][NB];
    int              n_checks = 0;
    int              n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int cfg_mode(input int c);
        return (c == 1) ? 1 : 0;
    endfunction

    function automatic int cfg_thr(input int c);
        return (c == 2) ? 500 : 32768;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // shift = max(floor(log2 M) - (OW-2), 0), with M = 0 giving 0.
    function automatic int ref_shift(input int m);
        int msb;
        int t;
        msb = 0;
        t   = m;
        while (t > 1) begin
            t = t >>> 1;
            msb++;
        end
        return (msb > OW - 2) ? msb - (OW - 2) : 0;
    endfunction

    // Reference model: expected outputs for every configuration from cur_blk.
    task automatic build_expected();
        int mx [NB];
        int gm, thr, sh, a, q, x;
        logic [N*OW-1:0] dv;
        logic [N-1:0]    mv;
        for (int c = 0; c < NCFG; c++) begin
            thr = cfg_thr(c);
            gm  = 0;
            for (int b = 0; b < NB; b++) begin
                mx[b] = 0;
                for (int e = 0; e < N; e++) begin
                    a = iabs(cur_blk[b][e]);
                    if (a <= thr && a > mx[b]) mx[b] = a;
                end
                if (mx[b] > gm) gm = mx[b];
            end
            for (int b = 0; b < NB; b++) begin
                sh = ref_shift((cfg_mode(c) == 1) ? mx[b] : gm);
                dv = '0;
                mv = '0;
                for (int e = 0; e < N; e++) begin
                    x = cur_blk[b][e];
                    a = iabs(x);
                    if (a > thr) begin
                        mv[e] = 1'b1;
                        q     = 0;
                    end else begin
                        q = (a + ((sh > 0) ? (1 << (sh - 1)) : 0)) >> sh;
                        if (q > 127) q = 127;
                        if (x < 0) q = -q;
                    end
                    dv[e*OW +: OW] = OW'(q);
                end
                exp_data[c][b]  = dv;
                exp_mask[c][b]  = mv;
                exp_shift[c][b] = sh;
            end
        end
    endtask

    task automatic set_blk(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3);
        cur_blk[0][0] = a0; cur_blk[0][1] = a1; cur_blk[0][2] = a2; cur_blk[0][3] = a3;
        cur_blk[1][0] = b0; cur_blk[1][1] = b1; cur_blk[1][2] = b2; cur_blk[1][3] = b3;
    endtask

    function automatic int rand_elem();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 255)) - 128;
            1: return int'($urandom_range(0, 4000)) - 2000;
            2: return int'($urandom_range(0, 65535)) - 32768;
            3: begin
                case ($urandom_range(0, 5))
                    0: return -32768;
                    1: return 32767;
                    2: return 500;
                    3: return -501;
                    4: return 1;
                    default: return 0;
                endcase
            end
            default: return int'($urandom_range(0, 15)) - 8;
        endcase
    endfunction

    task automatic drive_beat(input int b);
        logic [N*IW-1:0] v;
        v = '0;
        for (int e = 0; e < N; e++) v[e*IW +: IW] = IW'(cur_blk[b][e]);
        data_in = v;
    endtask

    // Offer nb beats with random valid gaps; inputs change only on negedges.
    task automatic send_block(input int nb);
        int  tries;
        bit  done;
        for (int b = 0; b < nb; b++) begin
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge clk);
                drive_beat(b);
                data_in_valid = ($urandom_range(0, 3) != 0);
                done  = data_in_valid && rdy[0];
                tries++;
                if (!done && tries > 50) begin
                    check("send_timeout_ready", rdy[0], 1'b1);
                    done = 1'b1;
                end
            end
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        if (nb == NB) begin
            check("calc_ready_low", rdy[0], 1'b0);
            check("calc_valid_low", vld[0], 1'b0);
        end
    endtask

    // Drain one block with random ready, comparing every valid cycle.
    task automatic receive_block(input bit stall);
        int k, cyc, stalls;
        k      = 0;
        cyc    = 0;
        stalls = 0;
        while (k < NB && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("latency_valid", vld[0], 1'b1);
            data_out_ready = 1'b0;
            if (vld[0]) begin
                for (int c = 0; c < NCFG; c++) begin
                    check($sformatf("c%0d_b%0d_data", c, k), dout[c], exp_data[c][k]);
                    check($sformatf("c%0d_b%0d_mask", c, k), mask[c], exp_mask[c][k]);
                    check($sformatf("c%0d_b%0d_shift", c, k), shft[c], exp_shift[c][k]);
                    check($sformatf("c%0d_b%0d_last", c, k), lst[c], (k == NB - 1));
                    check($sformatf("c%0d_b%0d_valid", c, k), vld[c], 1'b1);
                end
                if (stall && stalls < 5) stalls++;
                else data_out_ready = ($urandom_range(0, 2) != 0);
                if (data_out_ready) k++;
            end
        end
        if (k < NB) check("recv_timeout_valid", vld[0], 1'b1);
        @(negedge clk);
        data_out_ready = 1'b0;
        check("post_block_ready", rdy[0], 1'b1);
        check("post_block_valid", vld[0], 1'b0);
    endtask

    task automatic run_block(input bit stall);
        build_expected();
        send_block(NB);
        receive_block(stall);
    endtask

    task automatic check_reset_state(input string tag);
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("%s_c%0d_valid", tag, c), vld[c], 1'b0);
            check($sformatf("%s_c%0d_last", tag, c), lst[c], 1'b0);
            check($sformatf("%s_c%0d_data", tag, c), dout[c], '0);
            check($sformatf("%s_c%0d_mask", tag, c), mask[c], '0);
            check($sformatf("%s_c%0d_shift", tag, c), shft[c], '0);
            check($sformatf("%s_c%0d_ready", tag, c), rdy[c], 1'b1);
        end
    endtask

    initial begin
        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b1;

        // Reference block, saturation block, all-zero block.
        set_blk(100, -50, 3, 0, 20, -1000, 7, 1);
        run_block(1'b0);
        set_blk(255, -255, 0, 0, 0, 0, 0, 0);
        run_block(1'b0);
        set_blk(0, 0, 0, 0, 0, 0, 0, 0);
        run_block(1'b0);

        // Five cycles of backpressure on the first output beat.
        set_blk(100, -50, 3, 0, 20, -1000, 7, 1);
        run_block(1'b1);

        // Reset while a block is being emitted, then the reference block again.
        set_blk(255, -255, 0, 0, 0, 0, 0, 0);
        build_expected();
        send_block(NB);
        @(negedge clk);
        check("pre_reset_valid", vld[0], 1'b1);
        rst = 1'b0;
        #1;
        check_reset_state("rst_emit");
        @(negedge clk);
        rst = 1'b1;
        set_blk(100, -50, 3, 0, 20, -1000, 7, 1);
        run_block(1'b0);

        // Reset after a partial block; its large absmax must not leak.
        set_blk(20, -1000, 7, 1, 0, 0, 0, 0);
        send_block(1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("rst_collect");
        @(negedge clk);
        rst = 1'b1;
        set_blk(255, -255, 0, 0, 0, 0, 0, 0);
        run_block(1'b0);

        // Randomised blocks.
        for (int r = 0; r < 40; r++) begin
            for (int b = 0; b < NB; b++) begin
                for (int e = 0; e < N; e++) cur_blk[b][e] = rand_elem();
            end
            run_block(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/llmint8_absmax_quantizer.md
LLMINT8_ABSMAX_QUANTIZER -- requirements
Module: llmint8_absmax_quantizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, signed fixed-point input element width.
REQ-002 SHALL have parameter IN_SIZE, default 4, elements per row per beat.
REQ-003 SHALL have parameter IN_PARALLELISM, default 1, rows per beat; N = IN_PARALLELISM*IN_SIZE elements per beat.
REQ-004 SHALL have parameter OUT_WIDTH, default 8, signed quantised element width.
REQ-005 SHALL have parameter NUM_BEATS, default 2, beats per tensor block (>=1).
REQ-006 SHALL have parameter SCALE_MODE, default 0, 0 = one scale per block, 1 = one scale per beat.
REQ-007 SHALL have parameter THRESHOLD, default 2^(IN_WIDTH-1), outlier threshold on |x|.
REQ-008 SHALL have port clk, input, 1, the single clock.
REQ-009 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port data_in, input, N x IN_WIDTH, signed elements.
REQ-011 SHALL have ports data_in_valid (input, 1) and data_in_ready (output, 1).
REQ-012 SHALL have port data_out, output, N x OUT_WIDTH, signed quantised elements.
REQ-013 SHALL have port outlier_mask, output, N, bit i set when element i is an outlier.
REQ-014 SHALL have port scale_shift, output, $clog2(IN_WIDTH)+1, right-shift applied to the current beat.
REQ-015 SHALL have ports data_out_valid (output, 1), data_out_ready (input, 1), data_out_last (output, 1, final beat of block).

Function
REQ-016 SHALL implement states COLLECT, CALC, EMIT; reset state COLLECT.
REQ-017 In COLLECT, data_in_ready SHALL be 1; each data_in_valid&&data_in_ready beat SHALL be written to buffer slot beat_cnt, and beat_cnt SHALL increment.
REQ-018 Element x SHALL be an outlier when |x| > THRESHOLD; |x| SHALL be computed as an IN_WIDTH-bit unsigned value (|-2^(IN_WIDTH-1)| = 2^(IN_WIDTH-1)).
REQ-019 A running absmax M SHALL be kept over non-outlier elements only: per block (SCALE_MODE=0) or per beat slot (SCALE_MODE=1).
REQ-020 On acceptance of beat NUM_BEATS-1, the FSM SHALL go COLLECT->CALC; data_in_ready SHALL be 0 in CALC and EMIT.
REQ-021 In CALC (exactly one cycle), shift SHALL be registered as max(msb(M)-(OUT_WIDTH-2), 0), with msb(0) = 0; then CALC->EMIT.
REQ-022 Quantisation: q = sign(x) * ((|x| + (shift>0 ? 2^(shift-1) : 0)) >> shift), i.e. round-half-away-from-zero, saturated to +/-(2^(OUT_WIDTH-1)-1).
REQ-023 Outlier elements SHALL output q = 0 with the mask bit set; non-outliers SHALL have the mask bit clear.
REQ-024 In EMIT, data_out_valid SHALL be 1 and data_out/outlier_mask/scale_shift SHALL present slot emit_cnt; on data_out_ready, emit_cnt SHALL advance.
REQ-025 With data_out_valid=1 and data_out_ready=0, all outputs SHALL hold stable.
REQ-026 data_out_last SHALL be 1 exactly when emit_cnt = NUM_BEATS-1 in EMIT.
REQ-027 On handshake of the last beat, the FSM SHALL go EMIT->COLLECT, clear M and both counters; data_in_ready SHALL be 1 the next cycle.
REQ-028 Latency: first output beat valid 2 cycles after the last input beat is accepted; no beat SHALL be dropped or duplicated under any valid/ready pattern.
REQ-029 With NUM_BEATS=1, COLLECT SHALL transition to CALC on the first accepted beat.

Reset
REQ-030 rst low SHALL immediately force COLLECT, counters = 0, M = 0, data_out_valid = 0, data_out_last = 0, data_out = 0, outlier_mask = 0, scale_shift = 0, data_in_ready = 1 after release.
REQ-031 Reset asserted mid-COLLECT or mid-EMIT SHALL discard the partial block; the first block after release SHALL be quantised independently of it.

Verification (IN_WIDTH=16, OUT_WIDTH=8, IN_SIZE=4, IN_PARALLELISM=1, NUM_BEATS=2)
REQ-032 SCALE_MODE=0: beats [100,-50,3,0],[20,-1000,7,1] -> shift=3 both beats; out [13,-6,0,0],[3,-125,1,0]; last on beat 2.
REQ-033 SCALE_MODE=1, same stimulus -> beat 1 shift=0, [100,-50,3,0]; beat 2 shift=3, [3,-125,1,0].
REQ-034 SCALE_MODE=0, THRESHOLD=500, same stimulus -> mask beat 2 = 0b0010; M=100, shift=0; out [100,-50,3,0],[20,0,7,1].
REQ-035 Saturation/zero: block [255,-255,0,0],[0,0,0,0] -> shift=1, out [127,-127,0,0]; all-zero block -> shift=0, all outputs 0.
REQ-036 Backpressure and reset: hold data_out_ready=0 for 5 cycles in EMIT -> outputs stable; assert rst during EMIT -> valid=0 at once, next block output matches REQ-032.
